// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: a main slot plus a skid slot behind a registered in_ready, with synchronous flush.
// Optional stall counter is enabled by defining PIPE_STAGE_STALL_CNT_EN.
//
// state    | meaning
// ---------+-------------------------------------
// ST_EMPTY | main and skid slots both empty
// ST_BUSY  | main slot holds a beat, skid empty
// ST_FULL  | main and skid slots both hold beats
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
`ifdef PIPE_STAGE_STALL_CNT_EN
   ,parameter int CNT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STALL_CNT_EN
   ,output logic [CNT_W-1:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic [DATA_W-1:0]   m_data_q, m_data_d, s_data_q, s_data_d;
   logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
   logic                in_fire, out_fire;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = (state_q != ST_EMPTY) & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         m_data_q   <= '0;
         m_ctrl_q   <= '0;
         s_data_q   <= '0;
         s_ctrl_q   <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         m_data_q   <= m_data_d;
         m_ctrl_q   <= m_ctrl_d;
         s_data_q   <= s_data_d;
         s_ctrl_q   <= s_ctrl_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (in_fire) state_d = ST_BUSY;
            ST_BUSY: begin
               if (in_fire && !out_fire)      state_d = ST_FULL;
               else if (out_fire && !in_fire) state_d = ST_EMPTY;
            end
            ST_FULL:  if (out_fire) state_d = ST_BUSY;
            default:  state_d = ST_EMPTY;
         endcase
      end
      // in_ready is registered: it reflects whether the next state leaves the skid slot free
      in_ready_d = (state_d != ST_FULL);
   end

   always_comb begin
      m_data_d = m_data_q;
      m_ctrl_d = m_ctrl_q;
      s_data_d = s_data_q;
      s_ctrl_d = s_ctrl_q;
      if (flush) begin
         m_ctrl_d = '0;
         s_ctrl_d = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  m_data_d = in_data;
                  m_ctrl_d = in_ctrl;
               end
            end
            ST_BUSY: begin
               if (in_fire && out_fire) begin
                  m_data_d = in_data;
                  m_ctrl_d = in_ctrl;
               end else if (in_fire) begin
                  s_data_d = in_data;
                  s_ctrl_d = in_ctrl;
               end else if (out_fire) begin
                  m_ctrl_d = '0;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  m_data_d = s_data_q;
                  m_ctrl_d = s_ctrl_q;
                  s_ctrl_d = '0;
               end
            end
            default: begin
               m_ctrl_d = '0;
               s_ctrl_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      in_ready  = in_ready_q;
      out_valid = (state_q != ST_EMPTY);
      out_data  = m_data_q;
      out_ctrl  = m_ctrl_q;
   end

`ifdef PIPE_STAGE_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps then random traffic, checked against a queue model.
// Stall counter checks are included when PIPE_STAGE_STALL_CNT_EN is defined.
module tb_pipe_stage_reg;
   localparam int DW = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_STALL_CNT_EN
   localparam int SW = 4;
   logic [SW-1:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W(DW),
      .CTRL_W(CW)
`ifdef PIPE_STAGE_STALL_CNT_EN
      ,.CNT_W(SW)
`endif
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
`ifdef PIPE_STAGE_STALL_CNT_EN
      ,.stall_cnt(stall_cnt)
`endif
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } beat_t;

   beat_t         q[$];
   logic [DW-1:0] last_data;
   int            stall_m;
   int            vectors = 0;
   int            errors  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
      chk({tag, ".out_data"},  64'(out_data),  64'(last_data));
      chk({tag, ".out_ctrl"},  64'(out_ctrl),  (q.size() > 0) ? 64'(q[0].c) : 64'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
      chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(stall_m));
`endif
   endtask

   task automatic model_reset();
      q.delete();
      last_data = '0;
      stall_m   = 0;
   endtask

   // One clock: drive at negedge, advance the model at posedge, check just after.
   task automatic step(input string tag, input logic iv, input logic [DW-1:0] id,
                       input logic [CW-1:0] ic, input logic ordy, input logic fl);
      bit inf, outf;
      beat_t b;
      @(negedge clk);
      in_valid  = iv;
      in_data   = id;
      in_ctrl   = ic;
      out_ready = ordy;
      flush     = fl;
      inf  = iv && (q.size() < 2) && !fl;
      outf = (q.size() > 0) && ordy;
      if (q.size() > 0 && !ordy && stall_m < 15) stall_m++;
      @(posedge clk);
      #1;
      if (fl) begin
         q.delete();
      end else begin
         if (outf) void'(q.pop_front());
         if (inf) begin
            b.d = id;
            b.c = ic;
            q.push_back(b);
         end
      end
      if (q.size() > 0) last_data = q[0].d;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n, input logic ordy);
      for (int i = 0; i < n; i++) step(tag, 1'b0, '0, '0, ordy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
      model_reset();
      #2;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;
      idle("idle", 3, 1'b1);

      step("stream11", 1'b1, 32'h11, 8'h81, 1'b1, 1'b0);
      step("stream22", 1'b1, 32'h22, 8'h82, 1'b1, 1'b0);
      step("stream33", 1'b1, 32'h33, 8'h83, 1'b1, 1'b0);
      idle("stream_drain", 2, 1'b1);

      step("bp_a0", 1'b1, 32'hA0, 8'h10, 1'b0, 1'b0);
      step("bp_a1", 1'b1, 32'hA1, 8'h11, 1'b0, 1'b0);
      chk("bp_full_in_ready", 64'(in_ready), 64'd0);
      step("bp_a2_held", 1'b1, 32'hA2, 8'h12, 1'b0, 1'b0);
      chk("bp_a2_held_data", 64'(out_data), 64'hA0);
      step("bp_rel0", 1'b1, 32'hA2, 8'h12, 1'b1, 1'b0);
      step("bp_rel1", 1'b1, 32'hA2, 8'h12, 1'b1, 1'b0);
      chk("bp_a2_out", 64'(out_data), 64'hA2);
      idle("bp_drain", 2, 1'b1);

      step("fl_b0", 1'b1, 32'hB0, 8'h20, 1'b0, 1'b0);
      step("fl_b1", 1'b1, 32'hB1, 8'h21, 1'b0, 1'b0);
      step("flush_full", 1'b1, 32'h55, 8'h55, 1'b0, 1'b1);
      chk("flush_no55", 64'(out_data == 32'h55), 64'd0);
      step("post_flush", 1'b0, '0, '0, 1'b1, 1'b0);

      step("flo_c0", 1'b1, 32'hC0, 8'h30, 1'b1, 1'b0);
      step("flush_outfire", 1'b1, 32'hC1, 8'h31, 1'b1, 1'b1);

      step("ar_d0", 1'b1, 32'hD0, 8'h40, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_out_valid", 64'(out_valid), 64'd0);
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;
      idle("after_rst", 1, 1'b1);

`ifdef PIPE_STAGE_STALL_CNT_EN
      step("st_e0", 1'b1, 32'hE0, 8'h50, 1'b0, 1'b0);
      idle("stall", 20, 1'b0);
      chk("stall_sat", 64'(stall_cnt), 64'd15);
      step("stall_flush", 1'b0, '0, '0, 1'b0, 1'b1);
      chk("stall_after_flush", 64'(stall_cnt), 64'd15);
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      chk("stall_rst", 64'(stall_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;
`endif

      for (int i = 0; i < 500; i++) begin
         step("rand", 1'($urandom_range(0, 1)), $urandom, 8'($urandom),
              1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 15) == 0));
      end
      idle("final_drain", 3, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic elastic pipeline stage register that replaces fixed per-stage registers such as the EX/MEM latch. It carries a parametrised data payload plus a control field that is zeroed whenever the slot is empty. A valid/ready handshake and a 2-entry skid buffer give full throughput with registered `in_ready`. A synchronous flush squashes both entries for branch and jump redirects.

## Interface
Parameters:
- `DATA_W`, 32: payload width (ALU result, store data, branch target, rd, etc.).
- `CTRL_W`, 8: control-bit width (reg_write, mem_read, mem_write, branch, jump, …). These bits read zero whenever the stage holds no instruction.
- `CNT_W`, 16: stall counter width. Used only with `PIPE_STAGE_STALL_CNT_EN`.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `flush`, input, 1: synchronous squash of all held entries.
- `in_valid`, input, 1: upstream offers a beat.
- `in_ready`, output, 1: stage can accept a beat; registered.
- `in_data`, input, `DATA_W`: upstream payload.
- `in_ctrl`, input, `CTRL_W`: upstream control bits.
- `out_valid`, output, 1: main slot holds a beat.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_data`, output, `DATA_W`: main-slot payload.
- `out_ctrl`, output, `CTRL_W`: main-slot control; all zero when `out_valid`=0.
- `stall_cnt`, output, `CNT_W`: present only with `PIPE_STAGE_STALL_CNT_EN`.

## Operation
- Storage is a main slot M (drives the outputs) and a skid slot S.
- Input fire = `in_valid & in_ready`. Output fire = `out_valid & out_ready`.
- State machine:
  - EMPTY: M invalid, S invalid.
  - BUSY: M valid, S invalid.
  - FULL: M valid, S valid.
- `in_ready` = 1 in EMPTY and BUSY, 0 in FULL. It is a flop, not a function of `out_ready`.
- Transitions:
  - EMPTY + input fire: M ← in. Go to BUSY.
  - BUSY + input fire + output fire: M ← in. Stay in BUSY.
  - BUSY + input fire only: S ← in. Go to FULL.
  - BUSY + output fire only: go to EMPTY. M ctrl cleared.
  - FULL + output fire: M ← S. Go to BUSY.
  - All other cases: hold.
- Order is preserved; beats are never dropped or duplicated except by flush.
- `flush` beats every handshake:
  - Next state is EMPTY. M and S are invalidated and their ctrl fields zeroed.
  - A beat presented during the flush cycle is discarded even if `in_ready`=1.
  - `out_data` holds its last value; only validity and ctrl are cleared.
- Reset: state EMPTY, all data and ctrl registers zero.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0.
  - `out_data`=0, `out_ctrl`=0.
  - `stall_cnt`=0.
- Latency: a beat accepted at edge N appears on `out_*` after edge N, i.e. 1 cycle when EMPTY or BUSY-with-output-fire.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- Backpressure: `in_ready` falls one cycle after `out_ready` drops, if a beat was also accepted in that cycle. S absorbs that one extra beat.
- `in_ready` returns to 1 on the edge after the FULL-state output fire.
- Simultaneous flush and output fire: the downstream consumes the current beat, then the stage is EMPTY.
- `rst` asserted mid-transfer: all outputs go to their reset values immediately, without waiting for a clock edge.

## Configuration
- `PIPE_STAGE_STALL_CNT_EN` defined:
  - `stall_cnt` port exists.
  - It increments on every cycle with `out_valid & ~out_ready`.
  - It saturates at all-ones.
  - It is cleared only by `rst`, not by `flush`.
- Undefined: the port and counter logic are absent. Handshake behaviour is identical.

## Test plan
- Reset then idle: `rst` pulse → `in_ready`=1, `out_valid`=0, `out_ctrl`=0 throughout.
- Streaming: `out_ready`=1, beats `in_data`=0x11,0x22,0x33 on consecutive cycles → same values on `out_data` on the following consecutive cycles, each 1 cycle later, no bubbles.
- Backpressure and skid:
  - `out_ready`=0 while sending 0xA0, 0xA1 → `in_ready`=0 after the second accept, and 0xA2 is held off.
  - Raise `out_ready` → outputs 0xA0, 0xA1, 0xA2 in order.
- Flush when FULL: `flush`=1 with `in_valid`=1 and `in_data`=0x55 → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1, and 0x55 never appears.
- Async reset mid-stream: assert `rst` between edges while BUSY → `out_valid` drops before the next clock edge.
- With `PIPE_STAGE_STALL_CNT_EN`, `CNT_W`=4:
  - Hold `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_cnt` saturates at 15.
  - `flush` leaves it at 15; `rst` clears it to 0.
